// File: rtl/tone_pkg.sv
// Shared definitions for the tone path: sequencer state encoding and the
// default widths of a note-table entry (divider and length fields).
package tone_pkg;

    // Default width of the tone_gen divider value.
    localparam int unsigned TONE_DIV_W = 10;
    // Default width of a note length, in beat ticks.
    localparam int unsigned NOTE_LEN_W = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_LOAD = 2'd1,
        SEQ_PLAY = 2'd2,
        SEQ_GAP  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/note_sequencer_if.sv
// Control/status bundle of the note sequencer.
//   inputs to sequencer : start, stop, loop, tick, wr_en, wr_addr, wr_div, wr_len
//   outputs of sequencer: div, tone_rst, busy, note_idx, done
// master = controller side, slave = sequencer side.
interface note_sequencer_if #(
    parameter int unsigned WIDTH_COUNTER = tone_pkg::TONE_DIV_W,
    parameter int unsigned WIDTH_LEN     = tone_pkg::NOTE_LEN_W,
    parameter int unsigned DEPTH         = 16
) ();
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                     start;
    logic                     stop;
    logic                     loop;
    logic                     tick;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [WIDTH_COUNTER-1:0] wr_div;
    logic [WIDTH_LEN-1:0]     wr_len;
    logic [WIDTH_COUNTER-1:0] div;
    logic                     tone_rst;
    logic                     busy;
    logic [ADDR_W-1:0]        note_idx;
    logic                     done;

    modport master (
        output start, stop, loop, tick, wr_en, wr_addr, wr_div, wr_len,
        input  div, tone_rst, busy, note_idx, done
    );

    modport slave (
        input  start, stop, loop, tick, wr_en, wr_addr, wr_div, wr_len,
        output div, tone_rst, busy, note_idx, done
    );

endinterface

// File: rtl/note_table.sv
// Note storage: DEPTH entries of {div, len}, one synchronous write port and
// one combinational read port. Contents are not reset.
//   clk               : clock
//   wr_en/wr_addr     : write strobe and address
//   wr_div/wr_len     : entry to store
//   rd_addr           : read address
//   rd_div_c/rd_len_c : combinational read data
module note_table
    import tone_pkg::*;
#(
    parameter int unsigned WIDTH_COUNTER = TONE_DIV_W,
    parameter int unsigned WIDTH_LEN     = NOTE_LEN_W,
    parameter int unsigned DEPTH         = 16,
    localparam int unsigned ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH_COUNTER-1:0] wr_div,
    input  logic [WIDTH_LEN-1:0]     wr_len,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [WIDTH_COUNTER-1:0] rd_div_c,
    output logic [WIDTH_LEN-1:0]     rd_len_c
);

    logic [WIDTH_COUNTER-1:0] div_mem [DEPTH];
    logic [WIDTH_LEN-1:0]     len_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            div_mem[wr_addr] <= wr_div;
            len_mem[wr_addr] <= wr_len;
        end
    end

    // Read port
    assign rd_div_c = div_mem[rd_addr];
    assign rd_len_c = len_mem[rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// Plays a song from the note table: each entry drives the tone_gen divider
// for len beat ticks (div=0 is a rest, len=0 marks end of song), with an
// optional one-tick silent gap after each note.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of note_sequencer_if (control in, tone/status out)
module note_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned WIDTH_COUNTER = TONE_DIV_W,
    parameter int unsigned WIDTH_LEN     = NOTE_LEN_W,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned GAP_EN        = 1
) (
    input  logic            clk,
    input  logic            rst,
    note_sequencer_if.slave bus
);

    localparam int unsigned ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    seq_state_t               state_q, state_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic [WIDTH_LEN-1:0]     rem_q, rem_d;
    logic [WIDTH_COUNTER-1:0] div_lat_q, div_lat_d;
    logic                     done_d;
    logic                     adv_c;
    logic                     tbl_we_c;
    logic [WIDTH_COUNTER-1:0] rd_div_c;
    logic [WIDTH_LEN-1:0]     rd_len_c;

    logic [WIDTH_COUNTER-1:0] div_q;
    logic                     tone_rst_q;
    logic                     busy_q;
    logic                     done_q;

    // Table only accepts writes while idle
    assign tbl_we_c = bus.wr_en && (state_q == SEQ_IDLE);

    note_table #(
        .WIDTH_COUNTER (WIDTH_COUNTER),
        .WIDTH_LEN     (WIDTH_LEN),
        .DEPTH         (DEPTH)
    ) u_table (
        .clk      (clk),
        .wr_en    (tbl_we_c),
        .wr_addr  (bus.wr_addr),
        .wr_div   (bus.wr_div),
        .wr_len   (bus.wr_len),
        .rd_addr  (idx_q),
        .rd_div_c (rd_div_c),
        .rd_len_c (rd_len_c)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEQ_IDLE;
            idx_q     <= '0;
            rem_q     <= '0;
            div_lat_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            div_lat_q <= div_lat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        div_lat_d = div_lat_q;
        done_d    = 1'b0;
        adv_c     = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (bus.start) begin
                    state_d = SEQ_LOAD;
                    idx_d   = '0;
                end
            end
            SEQ_LOAD: begin
                if (rd_len_c == '0) begin
                    // End marker: looping replays entry 0 unless we are already on it
                    if (bus.loop && (idx_q != '0)) begin
                        idx_d = '0;
                    end else begin
                        done_d  = 1'b1;
                        state_d = SEQ_IDLE;
                    end
                end else begin
                    div_lat_d = rd_div_c;
                    rem_d     = rd_len_c;
                    state_d   = SEQ_PLAY;
                end
            end
            SEQ_PLAY: begin
                if (bus.tick) begin
                    rem_d = rem_q - WIDTH_LEN'(1);
                    if (rem_q == WIDTH_LEN'(1)) begin
                        if (GAP_EN != 0) begin
                            state_d = SEQ_GAP;
                        end else begin
                            adv_c = 1'b1;
                        end
                    end
                end
            end
            SEQ_GAP: begin
                if (bus.tick) begin
                    adv_c = 1'b1;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase

        // Step to the next entry; running off the table end counts as end of song
        if (adv_c) begin
            if (idx_q == LAST_IDX) begin
                if (bus.loop) begin
                    idx_d   = '0;
                    state_d = SEQ_LOAD;
                end else begin
                    done_d  = 1'b1;
                    state_d = SEQ_IDLE;
                end
            end else begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = SEQ_LOAD;
            end
        end

        // Abort beats everything else
        if (bus.stop) begin
            state_d = SEQ_IDLE;
            done_d  = 1'b0;
        end
    end

    // Registered outputs; tone controls follow the state one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= '0;
            tone_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            busy_q <= (state_d != SEQ_IDLE);
            done_q <= done_d;
            if (bus.stop) begin
                tone_rst_q <= 1'b1;
            end else begin
                tone_rst_q <= (state_q != SEQ_PLAY) || (div_lat_q == '0);
            end
            if (state_q == SEQ_PLAY) begin
                div_q <= div_lat_q;
            end
        end
    end

    assign bus.div      = div_q;
    assign bus.tone_rst = tone_rst_q;
    assign bus.busy     = busy_q;
    assign bus.note_idx = idx_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (with and without the gap tick)
// share one stimulus stream; a tick-level song model predicts the tone
// outputs at every beat and the number of done pulses per song.
module tb_note_sequencer;

    localparam int unsigned WC    = 10;
    localparam int unsigned WL    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    note_sequencer_if #(.WIDTH_COUNTER(WC), .WIDTH_LEN(WL), .DEPTH(DEPTH)) bus0 ();
    note_sequencer_if #(.WIDTH_COUNTER(WC), .WIDTH_LEN(WL), .DEPTH(DEPTH)) bus1 ();

    assign bus1.start   = bus0.start;
    assign bus1.stop    = bus0.stop;
    assign bus1.loop    = bus0.loop;
    assign bus1.tick    = bus0.tick;
    assign bus1.wr_en   = bus0.wr_en;
    assign bus1.wr_addr = bus0.wr_addr;
    assign bus1.wr_div  = bus0.wr_div;
    assign bus1.wr_len  = bus0.wr_len;

    note_sequencer #(.WIDTH_COUNTER(WC), .WIDTH_LEN(WL), .DEPTH(DEPTH), .GAP_EN(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    note_sequencer #(.WIDTH_COUNTER(WC), .WIDTH_LEN(WL), .DEPTH(DEPTH), .GAP_EN(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Song model state, index 0 = gap instance, 1 = no-gap instance
    int tbl_div [DEPTH];
    int tbl_len [DEPTH];
    bit m_active [2];
    int m_idx    [2];
    int m_left   [2];
    bit m_gap    [2];
    int m_div    [2];
    int done_exp [2];
    int done_seen[2];

    always @(negedge clk) begin
        if (bus0.done === 1'b1) done_seen[0]++;
        if (bus1.done === 1'b1) done_seen[1]++;
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic get_out(input int k, output int b, output int tr, output int dv,
                           output int ix, output int dn);
        if (k == 0) begin
            b = int'(bus0.busy); tr = int'(bus0.tone_rst); dv = int'(bus0.div);
            ix = int'(bus0.note_idx); dn = int'(bus0.done);
        end else begin
            b = int'(bus1.busy); tr = int'(bus1.tone_rst); dv = int'(bus1.div);
            ix = int'(bus1.note_idx); dn = int'(bus1.done);
        end
    endtask

    // Find the next playable note starting at m_idx, honouring end markers
    task automatic resolve(input int k);
        bit settled = 1'b0;
        for (int g = 0; g < 3 && !settled; g++) begin
            if (tbl_len[m_idx[k]] == 0) begin
                if (bus0.loop && m_idx[k] != 0) begin
                    m_idx[k] = 0;
                end else begin
                    m_active[k] = 1'b0;
                    done_exp[k]++;
                    settled = 1'b1;
                end
            end else begin
                m_left[k] = tbl_len[m_idx[k]];
                m_div[k]  = tbl_div[m_idx[k]];
                m_gap[k]  = 1'b0;
                settled   = 1'b1;
            end
        end
    endtask

    task automatic advance(input int k);
        if (m_idx[k] == DEPTH - 1) begin
            if (bus0.loop) begin
                m_idx[k] = 0;
                resolve(k);
            end else begin
                m_active[k] = 1'b0;
                done_exp[k]++;
            end
        end else begin
            m_idx[k]++;
            resolve(k);
        end
    endtask

    task automatic model_tick(input int k);
        if (m_active[k]) begin
            if (m_gap[k]) begin
                advance(k);
            end else begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    if (k == 0) m_gap[k] = 1'b1;
                    else        advance(k);
                end
            end
        end
    endtask

    task automatic model_start(input int k);
        if (!m_active[k]) begin
            m_active[k] = 1'b1;
            m_idx[k]    = 0;
            resolve(k);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0;
            m_idx[k]    = 0;
            m_gap[k]    = 1'b0;
            m_div[k]    = 0;
        end
    endtask

    task automatic check_all();
        int b, tr, dv, ix, dn;
        for (int k = 0; k < 2; k++) begin
            get_out(k, b, tr, dv, ix, dn);
            check_eq($sformatf("busy%0d", k), b, m_active[k]);
            check_eq($sformatf("div%0d", k), dv, m_div[k]);
            if (m_active[k]) begin
                check_eq($sformatf("note_idx%0d", k), ix, m_idx[k]);
                check_eq($sformatf("tone_rst%0d", k), tr, (m_gap[k] || m_div[k] == 0) ? 1 : 0);
            end else begin
                check_eq($sformatf("tone_rst_idle%0d", k), tr, 1);
            end
        end
    endtask

    task automatic check_reset();
        int b, tr, dv, ix, dn;
        for (int k = 0; k < 2; k++) begin
            get_out(k, b, tr, dv, ix, dn);
            check_eq($sformatf("rst_busy%0d", k), b, 0);
            check_eq($sformatf("rst_tone_rst%0d", k), tr, 1);
            check_eq($sformatf("rst_div%0d", k), dv, 0);
            check_eq($sformatf("rst_note_idx%0d", k), ix, 0);
            check_eq($sformatf("rst_done%0d", k), dn, 0);
        end
    endtask

    task automatic check_done();
        check_eq("done_cnt0", done_seen[0], done_exp[0]);
        check_eq("done_cnt1", done_seen[1], done_exp[1]);
    endtask

    task automatic write_entry(input int a, input int d, input int l);
        bus0.wr_en   = 1'b1;
        bus0.wr_addr = AW'(a);
        bus0.wr_div  = WC'(d);
        bus0.wr_len  = WL'(l);
        step();
        bus0.wr_en = 1'b0;
        if (!m_active[0] && !m_active[1]) begin
            tbl_div[a] = d;
            tbl_len[a] = l;
        end
    endtask

    task automatic start_song(input bit loop_v, input bit with_wr, input int d, input int l);
        bus0.loop  = loop_v;
        bus0.start = 1'b1;
        if (with_wr) begin
            bus0.wr_en   = 1'b1;
            bus0.wr_addr = '0;
            bus0.wr_div  = WC'(d);
            bus0.wr_len  = WL'(l);
        end
        step();
        bus0.start = 1'b0;
        bus0.wr_en = 1'b0;
        if (with_wr && !m_active[0] && !m_active[1]) begin
            tbl_div[0] = d;
            tbl_len[0] = l;
        end
        model_start(0);
        model_start(1);
    endtask

    // One beat: idle cycles, then a tick (optionally with stop / new loop level)
    task automatic do_tick(input int spacing, input bit new_loop, input bit with_stop);
        repeat (spacing - 1) step();
        bus0.loop = new_loop;
        bus0.tick = 1'b1;
        bus0.stop = with_stop;
        @(negedge clk);
        check_all();
        step();
        bus0.tick = 1'b0;
        bus0.stop = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (with_stop) m_active[k] = 1'b0;
            else           model_tick(k);
        end
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 20 && (bus0.busy || bus1.busy); c++) step();
        step();
        @(negedge clk);
        check_all();
        step();
        check_done();
    endtask

    task automatic play(input bit loop_v, input int drop_after);
        for (int t = 0; t < 400 && (m_active[0] || m_active[1]); t++) begin
            do_tick(int'($urandom_range(4, 6)), (t >= drop_after) ? 1'b0 : loop_v, 1'b0);
        end
        wait_idle();
    endtask

    task automatic load_demo_table();
        for (int a = 3; a < DEPTH; a++) write_entry(a, int'($urandom_range(0, 1023)), int'($urandom_range(1, 3)));
        write_entry(0, 5, 2);
        write_entry(1, 0, 1);
        write_entry(2, 9, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus0.start   = 1'b0;
        bus0.stop    = 1'b0;
        bus0.loop    = 1'b0;
        bus0.tick    = 1'b0;
        bus0.wr_en   = 1'b0;
        bus0.wr_addr = '0;
        bus0.wr_div  = '0;
        bus0.wr_len  = '0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            done_exp[k] = 0;
        end
        repeat (3) step();
        @(negedge clk);
        check_reset();
        step();
        rst = 1'b0;
        step();

        // Demo song: note, rest, end marker
        load_demo_table();
        start_song(1'b0, 1'b0, 0, 0);
        play(1'b0, 0);

        // Same song looping, then loop released
        start_song(1'b1, 1'b0, 0, 0);
        play(1'b1, 12);

        // Stop together with a tick mid-note, then replay from entry 0
        start_song(1'b0, 1'b0, 0, 0);
        do_tick(4, 1'b0, 1'b0);
        do_tick(5, 1'b0, 1'b1);
        @(negedge clk);
        check_all();
        step();
        check_done();
        start_song(1'b0, 1'b0, 0, 0);
        play(1'b0, 0);

        // Write while busy must not land
        start_song(1'b0, 1'b0, 0, 0);
        write_entry(0, 99, 3);
        play(1'b0, 0);
        start_song(1'b0, 1'b0, 0, 0);
        play(1'b0, 0);

        // Reset mid-note; table survives
        start_song(1'b0, 1'b0, 0, 0);
        do_tick(4, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset();
        step();
        check_done();
        start_song(1'b0, 1'b0, 0, 0);
        play(1'b0, 0);

        // Full table of one-tick notes, end of song by running off the table
        for (int a = 0; a < DEPTH; a++) write_entry(a, a + 1, 1);
        start_song(1'b0, 1'b0, 0, 0);
        play(1'b0, 0);

        // End marker at entry 0 with loop set must terminate
        write_entry(0, 3, 0);
        start_song(1'b1, 1'b0, 0, 0);
        wait_idle();

        // Longest note length
        write_entry(0, 7, 255);
        write_entry(1, 0, 0);
        start_song(1'b0, 1'b0, 0, 0);
        play(1'b0, 0);

        // Random tables, random looping, optional write in the start cycle
        for (int s = 0; s < 6; s++) begin
            bit lp;
            for (int a = 0; a < DEPTH; a++) begin
                int l;
                int d;
                l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
                d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 1023));
                write_entry(a, d, l);
            end
            lp = 1'($urandom_range(0, 1));
            start_song(lp, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                       int'($urandom_range(1, 3)));
            play(lp, int'($urandom_range(5, 40)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
